// File: rtl/kmer_stream_gen_if.sv
// Handshake bundle for the k-mer extractor: read input side, k-mer output side
// and the per-read control/status bits. The DUT uses the slave view.
interface kmer_stream_gen_if #(
    parameter int READ_LEN = 256,
    parameter int K        = 45,
    parameter int POS_W    = 8
);
    logic [2*READ_LEN-1:0] read_in;
    logic                  read_valid;
    logic                  read_ready;
    logic                  canon_en;
    logic                  abort;
    logic                  kmer_valid;
    logic                  kmer_ready;
    logic [2*K-1:0]        kmer_data;
    logic [POS_W-1:0]      kmer_pos;
    logic                  kmer_strand;
    logic                  kmer_last;
    logic                  busy;

    modport slave (
        input  read_in, read_valid, canon_en, abort, kmer_ready,
        output read_ready, kmer_valid, kmer_data, kmer_pos, kmer_strand, kmer_last, busy
    );

    modport master (
        output read_in, read_valid, canon_en, abort, kmer_ready,
        input  read_ready, kmer_valid, kmer_data, kmer_pos, kmer_strand, kmer_last, busy
    );
endinterface

// File: rtl/kmer_stream_gen.sv
// Streams every overlapping K-base window of a 2-bit encoded read, one per
// accepted handshake, with start position, last flag and optional canonical
// (strand-minimal) form.
//
// state | meaning
// IDLE  | waiting for a read, read_ready high
// EMIT  | presenting k-mer at r_pos, shifting on each accepted k-mer
module kmer_stream_gen #(
    parameter int READ_LEN = 256,
    parameter int K        = 45,
    parameter int POS_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    kmer_stream_gen_if.slave bus
);
    localparam int N = READ_LEN - K + 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                r_state;
    logic [2*READ_LEN-1:0] r_shift;
    logic [POS_W-1:0]      r_pos;
    logic                  r_canon;

    logic [2*K-1:0]        w_fwd;
    logic [2*K-1:0]        w_rc;
    logic                  w_use_rc;

    assign w_fwd = r_shift[2*READ_LEN-1 -: 2*K];

    // Reverse complement: complement each base and reverse the base order.
    always_comb begin
        w_rc = '0;
        for (int i = 0; i < K; i++) begin
            w_rc[2*i +: 2] = ~w_fwd[2*(K-1-i) +: 2];
        end
    end

    // Palindromes (rc == fwd) stay on the forward strand.
    assign w_use_rc = r_canon && (w_rc < w_fwd);

    assign bus.kmer_data   = w_use_rc ? w_rc : w_fwd;
    assign bus.kmer_strand = w_use_rc;
    assign bus.kmer_pos    = r_pos;
    assign bus.kmer_valid  = (r_state == EMIT);
    assign bus.kmer_last   = (r_state == EMIT) && (r_pos == LAST_POS);
    assign bus.read_ready  = (r_state == IDLE);
    assign bus.busy        = (r_state == EMIT);

    // Read capture, per-k-mer shift/advance and abort handling. The position
    // is not advanced on the final k-mer so it never exceeds N-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_pos   <= '0;
            r_canon <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.read_valid) begin
                        r_shift <= bus.read_in;
                        r_canon <= bus.canon_en;
                        r_pos   <= '0;
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (bus.kmer_ready) begin
                        if (r_pos == LAST_POS) begin
                            r_state <= IDLE;
                        end else begin
                            r_shift <= r_shift << 2;
                            r_pos   <= r_pos + POS_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kmer_stream_gen.sv
// Scoreboard bench for kmer_stream_gen: a small instance (READ_LEN=8, K=3)
// for directed and random cases and a default-geometry instance for random
// full-size reads. Expected k-mers are queued at stimulus time and popped by
// per-instance monitors on each accepted k-mer.
module tb_kmer_stream_gen;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    kmer_stream_gen_if #(.READ_LEN(8), .K(3), .POS_W(3)) s_if ();
    kmer_stream_gen_if #(.READ_LEN(256), .K(45), .POS_W(8)) b_if ();

    kmer_stream_gen #(.READ_LEN(8), .K(3), .POS_W(3)) u_small (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if)
    );

    kmer_stream_gen u_big (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if)
    );

    typedef struct {
        logic [89:0] data;
        int          pos;
        bit          strand;
        bit          last;
    } exp_t;

    exp_t sq[$];
    exp_t bq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [89:0] act, input logic [89:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: split the read into bases, form each window by arithmetic,
    // build the reverse complement from the base list and pick the smaller.
    task automatic model(input logic [511:0] rd, input int rlen, input int k,
                         input bit canon, input bit big);
        int   b[256];
        exp_t e;
        logic [89:0] f, r;
        for (int i = 0; i < rlen; i++) b[i] = int'(rd[2*rlen-1-2*i -: 2]);
        for (int p = 0; p <= rlen - k; p++) begin
            f = '0;
            r = '0;
            for (int j = 0; j < k; j++) begin
                f = (f << 2) | 90'(b[p+j]);
                r = (r << 2) | 90'(3 - b[p+k-1-j]);
            end
            e.pos    = p;
            e.last   = (p == rlen - k);
            e.strand = canon && (r < f);
            e.data   = e.strand ? r : f;
            if (big) bq.push_back(e); else sq.push_back(e);
        end
    endtask

    task automatic push_s(input logic [89:0] d, input int p, input bit s, input bit l);
        exp_t e;
        e.data = d; e.pos = p; e.strand = s; e.last = l;
        sq.push_back(e);
    endtask

    // Small-instance monitor: scoreboard pop on handshake, stability under stall.
    logic [5:0] s_pd;
    logic [2:0] s_pp;
    logic       s_ps, s_pl;
    bit         s_stall = 0;
    exp_t       s_e;
    always @(negedge clk) begin
        if (!reset) begin
            s_stall = 0;
        end else begin
            if (s_stall && s_if.kmer_valid) begin
                check("s_hold_data",   90'(s_if.kmer_data),   90'(s_pd));
                check("s_hold_pos",    90'(s_if.kmer_pos),    90'(s_pp));
                check("s_hold_strand", 90'(s_if.kmer_strand), 90'(s_ps));
                check("s_hold_last",   90'(s_if.kmer_last),   90'(s_pl));
            end
            if (s_if.kmer_valid && s_if.kmer_ready) begin
                if (sq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL s_unexpected: actual pos=%0d expected none", s_if.kmer_pos);
                end else begin
                    s_e = sq.pop_front();
                    check("s_data",   90'(s_if.kmer_data),   s_e.data);
                    check("s_pos",    90'(s_if.kmer_pos),    90'(s_e.pos));
                    check("s_strand", 90'(s_if.kmer_strand), 90'(s_e.strand));
                    check("s_last",   90'(s_if.kmer_last),   90'(s_e.last));
                end
            end
            s_stall = s_if.kmer_valid && !s_if.kmer_ready;
            s_pd = s_if.kmer_data;
            s_pp = s_if.kmer_pos;
            s_ps = s_if.kmer_strand;
            s_pl = s_if.kmer_last;
        end
    end

    // Default-instance monitor.
    logic [89:0] b_pd;
    logic [7:0]  b_pp;
    logic        b_ps, b_pl;
    bit          b_stall = 0;
    exp_t        b_e;
    always @(negedge clk) begin
        if (!reset) begin
            b_stall = 0;
        end else begin
            if (b_stall && b_if.kmer_valid) begin
                check("b_hold_data", b_if.kmer_data, b_pd);
                check("b_hold_pos",  90'(b_if.kmer_pos), 90'(b_pp));
                check("b_hold_sl",   90'({b_if.kmer_strand, b_if.kmer_last}), 90'({b_ps, b_pl}));
            end
            if (b_if.kmer_valid && b_if.kmer_ready) begin
                if (bq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected: actual pos=%0d expected none", b_if.kmer_pos);
                end else begin
                    b_e = bq.pop_front();
                    check("b_data",   b_if.kmer_data,          b_e.data);
                    check("b_pos",    90'(b_if.kmer_pos),      90'(b_e.pos));
                    check("b_strand", 90'(b_if.kmer_strand),   90'(b_e.strand));
                    check("b_last",   90'(b_if.kmer_last),     90'(b_e.last));
                end
            end
            b_stall = b_if.kmer_valid && !b_if.kmer_ready;
            b_pd = b_if.kmer_data;
            b_pp = b_if.kmer_pos;
            b_ps = b_if.kmer_strand;
            b_pl = b_if.kmer_last;
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic send_s(input logic [15:0] rd, input bit canon, input bit use_model, input bit ab);
        int t = 0;
        while (!s_if.read_ready && t < 100) begin @(posedge clk); #1; t++; end
        check("s_accept_timeout", 90'(t >= 100), 90'(0));
        if (use_model) model({496'b0, rd}, 8, 3, canon, 0);
        s_if.read_in    = rd;
        s_if.canon_en   = canon;
        s_if.abort      = ab;
        s_if.read_valid = 1'b1;
        @(posedge clk); #1;
        s_if.read_valid = 1'b0;
        s_if.abort      = 1'b0;
        s_if.canon_en   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain_s(input bit rnd);
        int t = 0;
        while ((s_if.kmer_valid || !s_if.read_ready) && t < 200) begin
            if (rnd) s_if.kmer_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        s_if.kmer_ready = 1'b1;
        check("s_drain_timeout", 90'(t >= 200), 90'(0));
        check("s_queue_empty", 90'(sq.size()), 90'(0));
    endtask

    task automatic send_b(input logic [511:0] rd, input bit canon);
        int t = 0;
        while (!b_if.read_ready && t < 100) begin @(posedge clk); #1; t++; end
        check("b_accept_timeout", 90'(t >= 100), 90'(0));
        model(rd, 256, 45, canon, 1);
        b_if.read_in    = rd;
        b_if.canon_en   = canon;
        b_if.read_valid = 1'b1;
        @(posedge clk); #1;
        b_if.read_valid = 1'b0;
        b_if.canon_en   = 1'($urandom_range(0, 1));
    endtask

    task automatic drain_b(input bit rnd);
        int t = 0;
        while ((b_if.kmer_valid || !b_if.read_ready) && t < 2000) begin
            if (rnd) b_if.kmer_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            t++;
        end
        b_if.kmer_ready = 1'b1;
        check("b_drain_timeout", 90'(t >= 2000), 90'(0));
        check("b_queue_empty", 90'(bq.size()), 90'(0));
    endtask

    task automatic check_reset_vals();
        check("rst_read_ready", 90'(s_if.read_ready),  90'(1));
        check("rst_kmer_valid", 90'(s_if.kmer_valid),  90'(0));
        check("rst_kmer_data",  90'(s_if.kmer_data),   90'(0));
        check("rst_kmer_pos",   90'(s_if.kmer_pos),    90'(0));
        check("rst_kmer_strand",90'(s_if.kmer_strand), 90'(0));
        check("rst_kmer_last",  90'(s_if.kmer_last),   90'(0));
        check("rst_busy",       90'(s_if.busy),        90'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] big_rd;
        int c;
        s_if.read_in = '0; s_if.read_valid = 0; s_if.canon_en = 0; s_if.abort = 0; s_if.kmer_ready = 1;
        b_if.read_in = '0; b_if.read_valid = 0; b_if.canon_en = 0; b_if.abort = 0; b_if.kmer_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b1;
        @(posedge clk); #1;

        // ACGTACGT, forward strand, full throughput
        push_s(90'h06, 0, 0, 0); push_s(90'h1B, 1, 0, 0); push_s(90'h2C, 2, 0, 0);
        push_s(90'h31, 3, 0, 0); push_s(90'h06, 4, 0, 0); push_s(90'h1B, 5, 0, 1);
        send_s(16'h1B1B, 0, 0, 0);
        check("latency_valid", 90'(s_if.kmer_valid), 90'(1));
        check("latency_pos",   90'(s_if.kmer_pos),   90'(0));
        check("emit_ready_low",90'(s_if.read_ready), 90'(0));
        c = 0;
        while (s_if.kmer_valid && c < 20) begin @(posedge clk); #1; c++; end
        check("emit_cycles", 90'(c), 90'(6));
        check("ready_after", 90'(s_if.read_ready), 90'(1));
        check("s_queue_t1", 90'(sq.size()), 90'(0));

        // Same read, canonical; abort asserted in IDLE must not block accept
        push_s(90'h06, 0, 0, 0); push_s(90'h06, 1, 1, 0); push_s(90'h2C, 2, 0, 0);
        push_s(90'h2C, 3, 1, 0); push_s(90'h06, 4, 0, 0); push_s(90'h06, 5, 1, 1);
        send_s(16'h1B1B, 1, 0, 1);
        drain_s(0);

        // Random reads under random back-pressure
        for (int i = 0; i < 6; i++) begin
            send_s(16'($urandom), 1'($urandom_range(0, 1)), 1, 0);
            drain_s(1);
        end

        // Abort at pos 2 with ready high
        send_s(16'($urandom), 1'($urandom_range(0, 1)), 1, 0);
        c = 0;
        while (s_if.kmer_pos != 3'd2 && c < 20) begin @(posedge clk); #1; c++; end
        check("abort_reach_timeout", 90'(c >= 20), 90'(0));
        s_if.abort = 1'b1;
        @(posedge clk); #1;
        s_if.abort = 1'b0;
        check("abort_valid", 90'(s_if.kmer_valid), 90'(0));
        check("abort_ready", 90'(s_if.read_ready), 90'(1));
        check("abort_busy",  90'(s_if.busy),       90'(0));
        check("abort_left",  90'(sq.size()),       90'(3));
        sq.delete();
        send_s(16'($urandom), 1'($urandom_range(0, 1)), 1, 0);
        check("abort_restart_pos", 90'(s_if.kmer_pos), 90'(0));
        drain_s(0);

        // Reset mid-read at pos 3
        send_s(16'($urandom), 1, 1, 0);
        c = 0;
        while (s_if.kmer_pos != 3'd3 && c < 20) begin @(posedge clk); #1; c++; end
        check("reset_reach_timeout", 90'(c >= 20), 90'(0));
        reset = 1'b0;
        #1;
        check_reset_vals();
        sq.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        send_s(16'($urandom), 1'($urandom_range(0, 1)), 1, 0);
        check("reset_restart_valid", 90'(s_if.kmer_valid), 90'(1));
        check("reset_restart_pos",   90'(s_if.kmer_pos),   90'(0));
        drain_s(1);

        // Default geometry: 212 k-mers per read
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) big_rd[32*i +: 32] = $urandom;
            send_b(big_rd, 1'(r % 2));
            if (r == 0) begin
                c = 0;
                while (b_if.kmer_valid && c < 400) begin @(posedge clk); #1; c++; end
                check("b_emit_cycles", 90'(c), 90'(212));
                check("b_queue_t0",    90'(bq.size()), 90'(0));
            end else begin
                drain_b(1);
            end
        end

        repeat (2) @(posedge clk);
        #1;
        check("s_final_empty", 90'(sq.size()), 90'(0));
        check("b_final_empty", 90'(bq.size()), 90'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kmer_stream_gen.md
# kmer_stream_gen

Parametrised k-mer extractor: accepts one 2-bit-encoded DNA read per transaction and emits every overlapping k-mer, one per cycle, tagged with its start position, a last flag and, optionally, its canonical (strand-minimal) form. It sits between the read input buffer and the k-mer counting/hash stage of the error-correction pipeline. It replaces the fixed 512-bit / 45-base extractor with a handshaked, back-pressurable stream and configurable geometry.

## Interface
- READ_LEN, 256: read length in bases; read bus is 2*READ_LEN bits.
- K, 45: k-mer length in bases; 1 <= K <= READ_LEN.
- POS_W, 8: position width; 2^POS_W >= READ_LEN-K+1.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- read_in  in  2*READ_LEN  read; base 0 in bits [2*READ_LEN-1:2*READ_LEN-2]; A=00 C=01 G=10 T=11.
- read_valid  in  1  read_in valid.
- read_ready  out  1  block can accept a read.
- canon_en  in  1  canonical mode; sampled with the read.
- abort  in  1  synchronous flush of the current read.
- kmer_valid  out  1  k-mer output valid.
- kmer_ready  in  1  downstream accepts the k-mer.
- kmer_data  out  2*K  k-mer, first base in MSBs (canonical form if canon_en latched).
- kmer_pos  out  POS_W  start base index of the k-mer in the read (0-based).
- kmer_strand  out  1  1 = kmer_data is the reverse complement; 0 otherwise / canon off.
- kmer_last  out  1  high with the final k-mer of the read (pos = READ_LEN-K).
- busy  out  1  read in progress (state EMIT).

## Operation
- States: IDLE, EMIT. N = READ_LEN-K+1 k-mers per read.
- IDLE: read_ready=1, kmer_valid=0. On read_valid&&read_ready: latch read_in into shift register, latch canon_en, clear position counter, go EMIT.
- EMIT: read_ready=0, kmer_valid=1. Forward k-mer = top 2*K bits of shift register. On kmer_valid&&kmer_ready: shift register left by 2 bits, pos+1. If handshake occurs with pos=N-1: go IDLE.
- Canonical: rc = bitwise NOT of forward with base order reversed. If canon latched and rc < forward (unsigned), kmer_data=rc, kmer_strand=1; else forward, strand 0. Palindrome (rc == forward) -> strand 0.
- kmer_last = EMIT && pos==N-1.
- abort in EMIT: next state IDLE, kmer_valid drops next cycle; any concurrent handshake counts as consumed; no further k-mers of that read. abort in IDLE: ignored; does not block a concurrent read accept.
- Position counter never wraps: limited to N-1 by the state transition.
- K == READ_LEN: single k-mer, pos 0, last=1.

## Timing
- Reset (asserted): state IDLE, read_ready=1, kmer_valid=0, kmer_data=0, kmer_pos=0, kmer_strand=0, kmer_last=0, busy=0; takes effect immediately, mid-read included, discarding the read.
- Accept at edge t -> kmer_valid=1 with pos 0 from t to t+1 (one-cycle latency).
- Throughput: 1 k-mer/cycle with kmer_ready held high; a read occupies N cycles in EMIT plus 1 IDLE cycle before the next accept (read_ready is low throughout EMIT).
- Back-pressure: with kmer_valid=1 and kmer_ready=0, kmer_data, kmer_pos, kmer_strand, kmer_last hold stable; no k-mer skipped or duplicated.
- read_ready is a function of state only (no combinational path from kmer_ready).
- canon_en changes during EMIT have no effect.

## Test plan
- READ_LEN=8, K=3, canon off, read ACGTACGT, kmer_ready=1 -> 6 k-mers 0x06,0x1B,0x2C,0x31,0x06,0x1B on consecutive cycles, pos 0..5, last only at pos 5, read_ready high the cycle after.
- Same read, canon on -> 0x06/s0, 0x06/s1, 0x2C/s0, 0x2C/s1, 0x06/s0, 0x06/s1.
- Back-pressure: kmer_ready toggled pseudo-randomly -> exactly 6 transfers, in order, outputs stable while stalled.
- abort asserted while pos=2 with ready high -> pos 0..2 delivered, kmer_valid 0 next cycle, read_ready 1; next read restarts at pos 0.
- Reset asserted mid-read (pos=3) -> outputs immediately at reset values; after release a new read emits from pos 0.
- Defaults (READ_LEN=256, K=45) random reads vs. reference model -> 212 k-mers, pos 0..211, data equal to read bits [511-2p : 422-2p].
